// File: rtl/reaction_control_pkg.sv
// Shared types and constants for the reaction tester control slice.
package reaction_control_pkg;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WAIT        = 3'd1,
    TIMING      = 3'd2,
    DONE        = 3'd3,
    FALSE_START = 3'd4,
    TIMEOUT     = 3'd5
  } state_t;

  // Fibonacci taps 16,14,13,11 -> bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam logic [3:0]  BCD_MAX      = 4'd9;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/reaction_control_if.sv
// Link between the reaction controller and the 4-digit BCD counter.
interface reaction_control_if;
  logic [3:0] BCD3;
  logic [3:0] BCD2;
  logic [3:0] BCD1;
  logic [3:0] BCD0;
  logic       CntClear;
  logic       CntEnable;

  modport master (
    input  BCD3, BCD2, BCD1, BCD0,
    output CntClear, CntEnable
  );

  modport slave (
    output BCD3, BCD2, BCD1, BCD0,
    input  CntClear, CntEnable
  );
endinterface

// File: rtl/reaction_control_button_sync.sv
// Two-flop synchroniser plus history flop; Rise is a one-cycle rising-edge strobe.
module button_sync (
  input  logic Clock,
  input  logic Resetn,
  input  logic Pin,
  output logic Rise
);

  logic meta;
  logic sync;
  logic hist;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      meta <= 1'b0;
      sync <= 1'b0;
      hist <= 1'b0;
    end else begin
      meta <= Pin;
      sync <= meta;
      hist <= sync;
    end
  end

  assign Rise = sync & ~hist;

endmodule

// File: rtl/reaction_control.sv
// Reaction tester control FSM: random delay, stimulus LED, ms-rate counter
// enables, false-start and 9999 ms timeout detection.
module reaction_control
  import reaction_control_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned TICK_HZ   = 1000,
  parameter int unsigned MIN_DELAY = 1000,
  parameter logic [15:0] LFSR_SEED = DEFAULT_SEED
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic               Start,
  input  logic               Stop,
  reaction_control_if.master cnt,
  output logic               Led,
  output logic               FalseStart,
  output logic               Timeout
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic          start_rise;
  logic          stop_rise;
  state_t        state;
  logic [PW-1:0] pre;
  logic [15:0]   delay;
  logic [15:0]   lfsr;
  logic          tick;
  logic          at9999;
  logic          enter_wait;

  button_sync u_start_sync (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Pin    (Start),
    .Rise   (start_rise)
  );

  button_sync u_stop_sync (
    .Clock  (Clock),
    .Resetn (Resetn),
    .Pin    (Stop),
    .Rise   (stop_rise)
  );

  assign tick   = (pre == PW'(DIV - 1));
  assign at9999 = (cnt.BCD3 == BCD_MAX) && (cnt.BCD2 == BCD_MAX) &&
                  (cnt.BCD1 == BCD_MAX) && (cnt.BCD0 == BCD_MAX);

  // Start is honoured only outside WAIT/TIMING; this cycle is the WAIT entry.
  assign enter_wait = start_rise &&
                      (state inside {IDLE, DONE, FALSE_START, TIMEOUT});

  assign cnt.CntClear  = enter_wait;
  assign cnt.CntEnable = (state == TIMING) & tick & ~stop_rise & ~at9999;

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= lfsr_step(lfsr);
    end
  end

  // Restart from zero on clear so the first tick lands exactly DIV cycles later.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      pre <= '0;
    end else if (enter_wait || tick) begin
      pre <= '0;
    end else begin
      pre <= pre + PW'(1);
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state      <= IDLE;
      delay      <= '0;
      Led        <= 1'b0;
      FalseStart <= 1'b0;
      Timeout    <= 1'b0;
    end else begin
      case (state)
        WAIT: begin
          if (stop_rise) begin
            state      <= FALSE_START;
            FalseStart <= 1'b1;
          end else if (tick) begin
            delay <= delay - 16'd1;
            if (delay == 16'd1) begin
              state <= TIMING;
              Led   <= 1'b1;
            end
          end
        end
        TIMING: begin
          if (stop_rise) begin
            state <= DONE;
            Led   <= 1'b0;
          end else if (tick && at9999) begin
            state   <= TIMEOUT;
            Led     <= 1'b0;
            Timeout <= 1'b1;
          end
        end
        default: begin
          if (enter_wait) begin
            state      <= WAIT;
            delay      <= 16'(MIN_DELAY) + {5'b0, lfsr[10:0]};
            Led        <= 1'b0;
            FalseStart <= 1'b0;
            Timeout    <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/reaction_control.md
Name: reaction_control

Overview:
Control FSM for the reaction tester; sits directly upstream of the 4-digit BCD counter and drives its Clear and Enable inputs. On Start it waits a pseudo-random delay, lights the stimulus LED, then issues one counter enable per millisecond tick until Stop is pressed. It also flags false starts and the 9999 ms timeout. The block reads the counter's BCD digits back to detect the 9999 ms limit.

Parameters:
CLK_HZ, 50000000, system clock frequency.
TICK_HZ, 1000, counter enable rate; prescaler divide DIV = CLK_HZ/TICK_HZ. DIV must be at least 2.
MIN_DELAY, 1000, minimum random delay in ticks.
LFSR_SEED, 16'hACE1, non-zero reset value of the LFSR.

Ports:
Clock  in  1  system clock; all state changes on its rising edge.
Resetn  in  1  asynchronous, active-low reset.
Start  in  1  raw start button, active high, asynchronous to Clock.
Stop  in  1  raw reaction button, active high, asynchronous to Clock.
BCD3..BCD0  in  4 each  counter digits fed back from the BCD counter.
CntClear  out  1  drives the counter's Clear input.
CntEnable  out  1  drives the counter's Enable input; 1-cycle pulses.
Led  out  1  stimulus LED.
FalseStart  out  1  Stop was pressed before the LED lit.
Timeout  out  1  count reached 9999 without Stop.

Behaviour:
- Reset: state IDLE; all outputs 0; prescaler 0; delay counter 0; LFSR = LFSR_SEED; synchroniser flops 0.
- Inputs: Start and Stop each pass a 2-flop synchroniser plus a history flop; edge = sync & ~hist.
- Edge latency: a pin rising before clock edge k yields an edge during the cycle after edge k+1. The FSM acts at edge k+2.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11; advances every cycle in all states.
- Prescaler: counts 0..DIV-1. Tick is high for one cycle when the count equals DIV-1. The prescaler is forced to 0 in any cycle where CntClear=1, so the first tick after a restart comes exactly DIV cycles later.
- States and transitions:
  - IDLE: Start edge -> WAIT.
  - WAIT: Led=0. The delay counter decrements on each tick.
    - Stop edge -> FALSE_START; Stop has priority over the delay expiring in the same cycle.
    - Tick with delay counter == 1 -> TIMING.
  - TIMING: Led=1; CntEnable = tick.
    - Stop edge -> DONE. CntEnable is suppressed in that cycle even if tick=1.
    - Tick with BCD digits = 9,9,9,9 -> TIMEOUT. CntEnable is suppressed, so the counter holds at 9999.
  - DONE: Led=0; count held (CntEnable=0, CntClear=0).
  - FALSE_START: FalseStart=1, Led=0.
  - TIMEOUT: Timeout=1, Led=0.
  - DONE, FALSE_START, TIMEOUT: Start edge -> WAIT.
- Entering WAIT, from any state, is one atomic cycle:
  - CntClear=1 for exactly that cycle.
  - Delay counter loaded with MIN_DELAY + {5'b0, LFSR[10:0]}, giving a range of MIN_DELAY to MIN_DELAY+2047. Delay counter width is 16 bits.
  - FalseStart and Timeout cleared.
- Start edges in WAIT or TIMING are ignored. Stop edges in IDLE, DONE, FALSE_START and TIMEOUT are ignored.
- Simultaneous Start and Stop edges: the rule for the current state applies; the other edge is dropped.
- Resetn is asserted asynchronously at any point, including mid-TIMING, and forces the reset values immediately. The counter is not cleared until the next Start.
- All outputs are registered or decoded from registered state only. CntEnable = (state==TIMING) & tick & ~stop_edge & ~at9999.

Decomposition:
- Shared package: state encoding (IDLE, WAIT, TIMING, DONE, FALSE_START, TIMEOUT as 3-bit localparams), LFSR tap mask, default seed, BCD_MAX digit constant 4'd9.
- One sub-module, button_sync: 2-flop synchroniser, history flop and rising-edge output. Instantiated twice, for Start and Stop.

Test Plan:
All scenarios use CLK_HZ=10, TICK_HZ=1 (DIV=10), MIN_DELAY=2, LFSR_SEED=16'h0001. Sub-module counter model attached.
1. Reset then Start pulse -> CntClear high for 1 cycle at edge k+2; state WAIT. Loaded delay = 2 + LFSR[10:0] at that cycle (checked against the model). Led rises exactly delay×10 cycles later.
2. In TIMING, Stop after 3 ticks -> exactly 3 CntEnable pulses, each 10 cycles apart; BCD0=3; DONE; Led=0.
3. Stop during WAIT -> FALSE_START, FalseStart=1, no CntEnable ever issued. Then Start -> FalseStart=0, CntClear pulse, WAIT.
4. Preload the counter model to 9998 in TIMING -> one more enable gives 9999. The next tick moves to TIMEOUT with no enable; Timeout=1; digits stay 9,9,9,9.
5. Stop edge coincident with a tick in TIMING -> no CntEnable in that cycle; DONE. A Start edge during TIMING is ignored.
6. Resetn low mid-TIMING, asynchronously between clock edges -> Led, CntEnable, Timeout and FalseStart go 0 immediately; state IDLE; LFSR = seed.
